// File: rtl/nx_fifo_1r1w_ptr_sched.sv
// Hardware-side sequencer for a 1R1W FIFO RAM: owns the pointers and occupancy,
// hides RAM read latency with a prefetch buffer and hands the RAM to software
// on request.
module nx_fifo_1r1w_ptr_sched #(
    parameter int N_DATA_BITS = 32,
    parameter int N_ENTRIES   = 16,
    parameter int RD_LATENCY  = 2,
    parameter int OBUF_DEPTH  = RD_LATENCY + 1,
    localparam int AW = $clog2(N_ENTRIES),
    localparam int OW = $clog2(N_ENTRIES + OBUF_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [N_DATA_BITS-1:0] wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [N_DATA_BITS-1:0] rd_data,
    input  logic                   flush,
    output logic                   hw_cs,
    output logic [AW-1:0]          hw_waddr,
    output logic [AW-1:0]          hw_raddr,
    output logic                   hw_we,
    output logic                   hw_re,
    output logic [N_DATA_BITS-1:0] hw_din,
    input  logic [N_DATA_BITS-1:0] hw_dout,
    input  logic                   hw_yield,
    output logic [OW-1:0]          occupancy,
    output logic                   yielded
);

    localparam int OIW = $clog2(OBUF_DEPTH);
    localparam logic [OW-1:0] MEM_MAX  = OW'(N_ENTRIES);
    localparam logic [OW-1:0] OBUF_MAX = OW'(OBUF_DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(N_ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_YIELDED = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [AW-1:0]          wptr_r, rptr_r;
    logic [OW-1:0]          mem_cnt_r, inflight_r, discard_r, obuf_cnt_r;
    logic [RD_LATENCY-1:0]  dl_r, dl_s;
    logic [N_DATA_BITS-1:0] obuf_r [OBUF_DEPTH];
    logic                   active_s, push_s, pop_s, re_s, ret_s, keep_s;
    logic [OW-1:0]          credit_s;
    logic [OIW-1:0]         wr_idx_s;

    // Data path and strobe decode. Reset gates the strobes so the RAM is
    // released immediately, even with reads in flight.
    assign active_s  = (state_r == ST_ACTIVE) && !rst;
    assign wr_ready  = active_s && !hw_yield && (mem_cnt_r < MEM_MAX) && !flush;
    assign push_s    = wr_valid && wr_ready;
    assign rd_valid  = (obuf_cnt_r != {OW{1'b0}});
    assign pop_s     = rd_valid && rd_ready && !flush;
    // Buffer slots already promised: held entries plus reads still returning.
    assign credit_s  = obuf_cnt_r + inflight_r - OW'(pop_s);
    assign re_s      = active_s && !hw_yield && !flush && (mem_cnt_r != {OW{1'b0}})
                       && (credit_s < OBUF_MAX);
    assign ret_s     = dl_r[RD_LATENCY-1];
    assign keep_s    = ret_s && (discard_r == {OW{1'b0}}) && !flush;
    assign wr_idx_s  = OIW'(obuf_cnt_r) - OIW'(pop_s);
    assign hw_we     = push_s;
    assign hw_re     = re_s;
    assign hw_waddr  = wptr_r;
    assign hw_raddr  = rptr_r;
    assign hw_din    = wr_data;
    assign hw_cs     = !rst && ((state_r == ST_ACTIVE) ||
                                ((state_r == ST_DRAIN) && (inflight_r != {OW{1'b0}})));
    assign yielded   = (state_r == ST_YIELDED);
    assign rd_data   = obuf_r[0];
    assign occupancy = mem_cnt_r + inflight_r - discard_r + obuf_cnt_r;

    // Ownership state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_ACTIVE;
        end else begin
            state_r <= state_s;
        end
    end

    // Ownership next-state: drain outstanding reads before handing the RAM over.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_ACTIVE: begin
                if (hw_yield) state_s = ST_DRAIN;
                else          state_s = ST_ACTIVE;
            end
            ST_DRAIN: begin
                if (inflight_r == {OW{1'b0}}) state_s = ST_YIELDED;
                else                          state_s = ST_DRAIN;
            end
            ST_YIELDED: begin
                if (!hw_yield) state_s = ST_ACTIVE;
                else           state_s = ST_YIELDED;
            end
            default: state_s = ST_ACTIVE;
        endcase
    end

    // Write/read pointers and count of entries resident in the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r    <= {AW{1'b0}};
            rptr_r    <= {AW{1'b0}};
            mem_cnt_r <= {OW{1'b0}};
        end else if (flush) begin
            wptr_r    <= {AW{1'b0}};
            rptr_r    <= {AW{1'b0}};
            mem_cnt_r <= {OW{1'b0}};
        end else begin
            if (push_s) wptr_r <= (wptr_r == PTR_LAST) ? {AW{1'b0}} : wptr_r + AW'(1);
            else        wptr_r <= wptr_r;
            if (re_s)   rptr_r <= (rptr_r == PTR_LAST) ? {AW{1'b0}} : rptr_r + AW'(1);
            else        rptr_r <= rptr_r;
            mem_cnt_r <= mem_cnt_r + OW'(push_s) - OW'(re_s);
        end
    end

    // Next value of the read-return delay line.
    always_comb begin
        dl_s    = dl_r << 1'b1;
        dl_s[0] = re_s;
    end

    // Read-return tracking; a flush marks every still-outstanding read for discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_r       <= {RD_LATENCY{1'b0}};
            inflight_r <= {OW{1'b0}};
            discard_r  <= {OW{1'b0}};
        end else begin
            dl_r       <= dl_s;
            inflight_r <= inflight_r + OW'(re_s) - OW'(ret_s);
            if (flush)                                  discard_r <= inflight_r - OW'(ret_s);
            else if (ret_s && (discard_r != {OW{1'b0}})) discard_r <= discard_r - OW'(1);
            else                                        discard_r <= discard_r;
        end
    end

    // Prefetch buffer: shift register with the head always at index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obuf_cnt_r <= {OW{1'b0}};
            for (int i = 0; i < OBUF_DEPTH; i++) obuf_r[i] <= {N_DATA_BITS{1'b0}};
        end else if (flush) begin
            obuf_cnt_r <= {OW{1'b0}};
        end else begin
            obuf_cnt_r <= obuf_cnt_r + OW'(keep_s) - OW'(pop_s);
            if (pop_s) begin
                for (int i = 0; i < OBUF_DEPTH - 1; i++) obuf_r[i] <= obuf_r[i+1];
            end
            if (keep_s) obuf_r[wr_idx_s] <= hw_dout;
        end
    end

    nx_fifo_1r1w_ptr_sched_chk #(.OW(OW), .OBUF_DEPTH(OBUF_DEPTH)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .keep     (keep_s),
        .pop      (pop_s),
        .obuf_cnt (obuf_cnt_r)
    );

endmodule

// Prefetch-buffer overflow checker.
module nx_fifo_1r1w_ptr_sched_chk #(
    parameter int OW         = 4,
    parameter int OBUF_DEPTH = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          keep,
    input logic          pop,
    input logic [OW-1:0] obuf_cnt
);
    // A returning word must always find a free buffer slot.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(keep && !pop && (obuf_cnt == OW'(OBUF_DEPTH))));
        end
    end
endmodule

// File: tb/tb_nx_fifo_1r1w_ptr_sched.sv
// Directed bench for nx_fifo_1r1w_ptr_sched with a small RAM model and a data scoreboard.
module tb_nx_fifo_1r1w_ptr_sched;
    localparam int DW  = 32;
    localparam int NE  = 4;
    localparam int RL  = 2;
    localparam int AW  = $clog2(NE);
    localparam int OW  = $clog2(NE + RL + 1) + 1;

    logic          clk = 1'b0;
    logic          rst, wr_valid, rd_ready, flush, hw_yield;
    logic [DW-1:0] wr_data, rd_data, hw_din, hw_dout;
    logic          wr_ready, rd_valid, hw_cs, hw_we, hw_re, yielded;
    logic [AW-1:0] hw_waddr, hw_raddr;
    logic [OW-1:0] occupancy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int held = 0;
    int re_cnt = 0;
    int exp_wa = 0;
    int exp_ra = 0;
    logic [DW-1:0] sb [$];

    nx_fifo_1r1w_ptr_sched #(.N_DATA_BITS(DW), .N_ENTRIES(NE), .RD_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .flush(flush),
        .hw_cs(hw_cs), .hw_waddr(hw_waddr), .hw_raddr(hw_raddr), .hw_we(hw_we), .hw_re(hw_re),
        .hw_din(hw_din), .hw_dout(hw_dout), .hw_yield(hw_yield), .occupancy(occupancy),
        .yielded(yielded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: address registered on hw_re, then an output flop (2-cycle latency).
    logic [DW-1:0] ram [NE];
    logic [DW-1:0] s1, s2;
    always @(posedge clk) begin
        if (hw_we) ram[hw_waddr] <= hw_din;
        if (hw_re) s1 <= ram[hw_raddr];
        s2 <= s1;
    end
    assign hw_dout = s2;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Per-cycle monitor: occupancy, address sequencing and popped data vs scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete(); held = 0; exp_wa = 0; exp_ra = 0;
        end else begin
            check("occupancy", 32'(occupancy), held);
            if (held == 0) check("rd_valid_empty", 32'(rd_valid), 32'd0);
            if (hw_we || hw_re) check("hw_cs_busy", 32'(hw_cs), 32'd1);
            if (yielded) begin
                check("yld_cs", 32'(hw_cs), 32'd0);
                check("yld_re", 32'(hw_re), 32'd0);
                check("yld_we", 32'(hw_we), 32'd0);
            end
            if (wr_valid && wr_ready) begin
                check("hw_we", 32'(hw_we), 32'd1);
                check("hw_waddr", 32'(hw_waddr), exp_wa);
                check("hw_din", hw_din, wr_data);
                sb.push_back(wr_data);
                exp_wa = (exp_wa + 1) % NE;
                held++;
            end else begin
                check("hw_we_idle", 32'(hw_we), 32'd0);
            end
            if (hw_re) begin
                check("hw_raddr", 32'(hw_raddr), exp_ra);
                exp_ra = (exp_ra + 1) % NE;
                re_cnt++;
            end
            if (rd_valid && rd_ready && !flush) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $error("FAIL pop_unexpected: observed 0x%0h expected no data", rd_data);
                end else begin
                    checks--;
                    check("pop_data", rd_data, sb.pop_front());
                end
                held--;
            end
            if (flush) begin
                sb.delete(); held = 0; exp_wa = 0; exp_ra = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [DW-1:0] d, input logic exp_acc);
        wr_valid = 1'b1;
        wr_data  = d;
        #1;
        check("wr_ready", 32'(wr_ready), 32'(exp_acc));
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_occ(input int target, input int bound, input string tag);
        for (int k = 0; k < bound; k++) begin
            if (32'(occupancy) == target) break;
            tick();
        end
        check(tag, 32'(occupancy), target);
    endtask

    initial begin
        int t0, lat, re0, steady;
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0; hw_yield = 1'b0;
        wr_data = '0;
        tick(); tick();
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_hw_cs", 32'(hw_cs), 32'd0);
        check("rst_hw_we", 32'(hw_we), 32'd0);
        check("rst_hw_re", 32'(hw_re), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_yielded", 32'(yielded), 32'd0);
        rst = 1'b0;
        tick();
        check("act_hw_cs", 32'(hw_cs), 32'd1);

        // 1: four back-to-back pushes with the consumer always ready.
        // Write in cycle 0, read issue in cycle 1, data on hw_dout in cycle 3,
        // registered into the buffer so rd_valid rises in cycle 4.
        rd_ready = 1'b1;
        re0 = re_cnt;
        t0 = cyc;
        for (int i = 0; i < 4; i++) push_one(32'hA0 + 32'(i), 1'b1);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (rd_valid) begin lat = cyc - t0; break; end
            tick();
        end
        check("first_rd_latency", 32'(lat), 32'(RL + 2));
        wait_occ(0, 20, "t1_drain");
        check("t1_re_count", 32'(re_cnt - re0), 32'd4);

        // 2: fill with consumer stalled, then drain across the pointer wrap.
        rd_ready = 1'b0;
        re0 = re_cnt;
        for (int i = 0; i < 6; i++) push_one(32'hC0 + 32'(i), 1'b1);
        repeat (4) tick();
        check("t2_re_count", 32'(re_cnt - re0), 32'd3);
        check("t2_occupancy6", 32'(occupancy), 32'd6);
        push_one(32'hC6, 1'b1);
        push_one(32'hC7, 1'b0);
        rd_ready = 1'b1;
        wait_occ(0, 30, "t2_drain");
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: yield handover right after a read issue.
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_one(32'hD0 + 32'(i), 1'b1);
        repeat (4) tick();
        rd_ready = 1'b1;
        #1;
        check("t3_issue_on_pop", 32'(hw_re), 32'd1);
        tick();
        rd_ready = 1'b0;
        hw_yield = 1'b1;
        #1;
        check("t3_cs_after_yield", 32'(hw_cs), 32'd1);
        check("t3_no_re_on_yield", 32'(hw_re), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (yielded) break;
            tick();
        end
        check("t3_yielded", 32'(yielded), 32'd1);
        check("t3_cs_released", 32'(hw_cs), 32'd0);
        push_one(32'hDE, 1'b0);
        rd_ready = 1'b1;
        wait_occ(1, 12, "t3_pops_while_yielded");
        rd_ready = 1'b0;
        #1;
        check("t3_rd_valid_low", 32'(rd_valid), 32'd0);
        hw_yield = 1'b0;
        tick();
        check("t3_cs_back", 32'(hw_cs), 32'd1);
        check("t3_unyielded", 32'(yielded), 32'd0);
        check("t3_resume_re", 32'(hw_re), 32'd1);
        check("t3_resume_raddr", 32'(hw_raddr), 32'd3);
        rd_ready = 1'b1;
        wait_occ(0, 12, "t3_drain");

        // 4: flush with two reads in flight.
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'hE0 + 32'(i), 1'b1);
        flush = 1'b1;
        #1;
        check("t4_flush_wr_ready", 32'(wr_ready), 32'd0);
        check("t4_flush_no_re", 32'(hw_re), 32'd0);
        tick();
        flush = 1'b0;
        check("t4_occ_after_flush", 32'(occupancy), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check("t4_rd_valid_stays_low", 32'(rd_valid), 32'd0);
            tick();
        end
        wr_valid = 1'b1;
        wr_data  = 32'hB5;
        #1;
        check("t4_waddr0", 32'(hw_waddr), 32'd0);
        tick();
        wr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rd_valid) break;
            tick();
        end
        check("t4_pop_b5", rd_data, 32'hB5);
        rd_ready = 1'b1;
        wait_occ(0, 10, "t4_drain");

        // 5: sustained push and pop every cycle.
        steady = 0;
        for (int i = 0; i < 100; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h5000_0000 + 32'(i);
            #1;
            if (i == 8) steady = 32'(occupancy);
            if (i >= 8) begin
                check("t5_wr_ready", 32'(wr_ready), 32'd1);
                check("t5_rd_valid", 32'(rd_valid), 32'd1);
                check("t5_occ_const", 32'(occupancy), steady);
            end
            tick();
        end
        wr_valid = 1'b0;
        wait_occ(0, 20, "t5_drain");

        // 6: asynchronous reset mid-stream.
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(32'hF0 + 32'(i), 1'b1);
        #1;
        rst = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'hFF;
        #1;
        check("t6_wr_ready", 32'(wr_ready), 32'd0);
        check("t6_hw_cs", 32'(hw_cs), 32'd0);
        check("t6_hw_we", 32'(hw_we), 32'd0);
        check("t6_hw_re", 32'(hw_re), 32'd0);
        check("t6_rd_valid", 32'(rd_valid), 32'd0);
        check("t6_occupancy", 32'(occupancy), 32'd0);
        check("t6_yielded", 32'(yielded), 32'd0);
        tick(); tick();
        rst = 1'b0;
        wr_valid = 1'b0;
        tick();
        wr_valid = 1'b1;
        wr_data  = 32'hF9;
        #1;
        check("t6_waddr0", 32'(hw_waddr), 32'd0);
        check("t6_we", 32'(hw_we), 32'd1);
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        wait_occ(0, 20, "t6_drain");
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
